// File: rtl/regfile_wb_sched.sv
// Writeback scheduler for the dual-write-port register file: merges pipeline WB results
// with buffered multiplier results, tracks busy registers and requests WB bubbles on starvation.
module regfile_wb_sched #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [3:0]  wb_a,
    input  logic [31:0] wb_d,
    input  logic        iss_valid,
    input  logic [3:0]  iss_lo_a,
    input  logic [3:0]  iss_hi_a,
    input  logic        iss_long,
    input  logic        mul_valid,
    output logic        mul_ready,
    input  logic        mul_long,
    input  logic [3:0]  mul_lo_a,
    input  logic [3:0]  mul_hi_a,
    input  logic [31:0] mul_lo_d,
    input  logic [31:0] mul_hi_d,
    output logic        we3,
    output logic [3:0]  wa3,
    output logic [31:0] wd3,
    output logic [3:0]  wa3_2,
    output logic [31:0] wd3_2,
    output logic [14:0] busy,
    output logic        wb_hold
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [3:0] PC_ADDR = 4'd15;

    typedef struct packed {
        logic        is_long;
        logic [3:0]  lo_a;
        logic [3:0]  hi_a;
        logic [31:0] lo_d;
        logic [31:0] hi_d;
    } entry_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_STARVE = 1'b1
    } state_t;

    // One-hot busy mask for a register; the PC has no busy bit.
    function automatic logic [14:0] addr_mask(input logic [3:0] a);
        addr_mask = (a == PC_ADDR) ? 15'd0 : (15'd1 << a);
    endfunction

    entry_t            fifo_mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [14:0]       busy_r;
    state_t            state_r;
    logic [SW-1:0]     starve_cnt_r;

    entry_t            head_s;
    entry_t            push_entry_s;
    logic              empty_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic              w1_en_s;
    logic [3:0]        w1_a_s;
    logic [31:0]       w1_d_s;
    logic              w2_en_s;
    logic [3:0]        w2_a_s;
    logic [31:0]       w2_d_s;
    logic              we_s;
    logic [3:0]        a1_s;
    logic [31:0]       d1_s;
    logic [3:0]        a2_s;
    logic [31:0]       d2_s;
    logic [14:0]       clr_mask_s;
    logic [14:0]       set_mask_s;
    logic [14:0]       busy_next_s;

    assign empty_s      = (count_r == {CW{1'b0}});
    assign full_s       = (count_r == CW'(DEPTH));
    assign mul_ready    = !full_s;
    assign push_s       = mul_valid && !full_s;
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign push_entry_s = '{is_long: mul_long, lo_a: mul_lo_a, hi_a: mul_hi_a,
                            lo_d: mul_lo_d, hi_d: mul_hi_d};

    // Arbitration: pick up to two write halves and decide whether the FIFO head pops.
    always_comb begin
        pop_s   = 1'b0;
        w1_en_s = 1'b0;
        w1_a_s  = 4'd0;
        w1_d_s  = 32'd0;
        w2_en_s = 1'b0;
        w2_a_s  = 4'd0;
        w2_d_s  = 32'd0;
        if (wb_valid) begin
            w1_en_s = (wb_a != PC_ADDR);
            w1_a_s  = wb_a;
            w1_d_s  = wb_d;
            if (!empty_s && !head_s.is_long && (head_s.lo_a != wb_a)) begin
                pop_s   = 1'b1;
                w2_en_s = (head_s.lo_a != PC_ADDR);
                w2_a_s  = head_s.lo_a;
                w2_d_s  = head_s.lo_d;
            end else begin
                pop_s   = 1'b0;
            end
        end else if (!empty_s) begin
            pop_s   = 1'b1;
            w1_en_s = (head_s.lo_a != PC_ADDR);
            w1_a_s  = head_s.lo_a;
            w1_d_s  = head_s.lo_d;
            // A long result aimed twice at one register degenerates to a lo-only write.
            if (head_s.is_long && (head_s.lo_a != head_s.hi_a)) begin
                w2_en_s = (head_s.hi_a != PC_ADDR);
                w2_a_s  = head_s.hi_a;
                w2_d_s  = head_s.hi_d;
            end else begin
                w2_en_s = 1'b0;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // Map surviving halves onto both ports; a lone write is mirrored onto port 2.
    always_comb begin
        we_s = 1'b0;
        a1_s = 4'd0;
        d1_s = 32'd0;
        a2_s = 4'd0;
        d2_s = 32'd0;
        if (w1_en_s && w2_en_s) begin
            we_s = 1'b1;
            a1_s = w1_a_s;
            d1_s = w1_d_s;
            a2_s = w2_a_s;
            d2_s = w2_d_s;
        end else if (w1_en_s) begin
            we_s = 1'b1;
            a1_s = w1_a_s;
            d1_s = w1_d_s;
            a2_s = w1_a_s;
            d2_s = w1_d_s;
        end else if (w2_en_s) begin
            we_s = 1'b1;
            a1_s = w2_a_s;
            d1_s = w2_d_s;
            a2_s = w2_a_s;
            d2_s = w2_d_s;
        end else begin
            we_s = 1'b0;
        end
    end

    // Scoreboard update: pops release destinations, new issues claim them and win ties.
    always_comb begin
        clr_mask_s = 15'd0;
        set_mask_s = 15'd0;
        if (pop_s) begin
            clr_mask_s = addr_mask(head_s.lo_a) | (head_s.is_long ? addr_mask(head_s.hi_a) : 15'd0);
        end else begin
            clr_mask_s = 15'd0;
        end
        if (iss_valid) begin
            set_mask_s = addr_mask(iss_lo_a) | (iss_long ? addr_mask(iss_hi_a) : 15'd0);
        end else begin
            set_mask_s = 15'd0;
        end
        busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end

    // FIFO storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= push_entry_s;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered regfile write ports and busy scoreboard.
    always_ff @(posedge clk) begin
        if (reset) begin
            we3    <= 1'b0;
            wa3    <= 4'd0;
            wd3    <= 32'd0;
            wa3_2  <= 4'd0;
            wd3_2  <= 32'd0;
            busy_r <= 15'd0;
        end else begin
            we3    <= we_s;
            wa3    <= a1_s;
            wd3    <= d1_s;
            wa3_2  <= a2_s;
            wd3_2  <= d2_s;
            busy_r <= busy_next_s;
        end
    end

    assign busy = busy_r;

    // Starvation FSM: a FIFO left undrained too long forces a WB bubble until the next pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_RUN;
            starve_cnt_r <= {SW{1'b0}};
            wb_hold      <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    wb_hold <= 1'b0;
                    if (pop_s || empty_s) begin
                        starve_cnt_r <= {SW{1'b0}};
                    end else if (starve_cnt_r == SW'(STARVE_LIMIT)) begin
                        state_r <= ST_STARVE;
                        wb_hold <= 1'b1;
                    end else begin
                        starve_cnt_r <= starve_cnt_r + SW'(1);
                    end
                end
                ST_STARVE: begin
                    if (pop_s) begin
                        state_r      <= ST_RUN;
                        wb_hold      <= 1'b0;
                        starve_cnt_r <= {SW{1'b0}};
                    end else begin
                        wb_hold      <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_RUN;
                    wb_hold      <= 1'b0;
                    starve_cnt_r <= {SW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_regfile_wb_sched;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [3:0]  wb_a;
    logic [31:0] wb_d;
    logic        iss_valid;
    logic [3:0]  iss_lo_a;
    logic [3:0]  iss_hi_a;
    logic        iss_long;
    logic        mul_valid;
    logic        mul_ready;
    logic        mul_long;
    logic [3:0]  mul_lo_a;
    logic [3:0]  mul_hi_a;
    logic [31:0] mul_lo_d;
    logic [31:0] mul_hi_d;
    logic        we3;
    logic [3:0]  wa3;
    logic [31:0] wd3;
    logic [3:0]  wa3_2;
    logic [31:0] wd3_2;
    logic [14:0] busy;
    logic        wb_hold;

    regfile_wb_sched #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_a(wb_a), .wb_d(wb_d),
        .iss_valid(iss_valid), .iss_lo_a(iss_lo_a), .iss_hi_a(iss_hi_a), .iss_long(iss_long),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_long(mul_long),
        .mul_lo_a(mul_lo_a), .mul_hi_a(mul_hi_a), .mul_lo_d(mul_lo_d), .mul_hi_d(mul_hi_d),
        .we3(we3), .wa3(wa3), .wd3(wd3), .wa3_2(wa3_2), .wd3_2(wd3_2),
        .busy(busy), .wb_hold(wb_hold)
    );

    typedef struct {
        bit          is_long;
        logic [3:0]  lo_a;
        logic [3:0]  hi_a;
        logic [31:0] lo_d;
        logic [31:0] hi_d;
    } m_entry_t;

    m_entry_t    m_q[$];
    m_entry_t    iss_q[$];
    bit [14:0]   m_busy;
    int          m_run;
    bit          m_starve;
    bit          exp_we;
    logic [3:0]  exp_a1;
    logic [31:0] exp_d1;
    logic [3:0]  exp_a2;
    logic [31:0] exp_d2;
    int          n_vec;
    int          n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: apply one clock's worth of the scheduling rules to the current inputs.
    task automatic model_step();
        m_entry_t    h;
        bit          has;
        bit          pop;
        bit          room;
        int          n_wr;
        logic [3:0]  wa[2];
        logic [31:0] wd[2];
        n_wr = 0;
        wa[0] = 4'd0; wa[1] = 4'd0; wd[0] = 32'd0; wd[1] = 32'd0;
        if (reset) begin
            m_q.delete();
            m_busy = '0; m_run = 0; m_starve = 0;
            exp_we = 0; exp_a1 = 4'd0; exp_d1 = 32'd0; exp_a2 = 4'd0; exp_d2 = 32'd0;
            return;
        end
        has  = (m_q.size() > 0);
        room = (m_q.size() < DEPTH);
        pop  = 0;
        if (has) h = m_q[0];
        if (wb_valid) begin
            if (wb_a != 4'd15) begin wa[n_wr] = wb_a; wd[n_wr] = wb_d; n_wr++; end
            if (has && !h.is_long && h.lo_a != wb_a) begin
                pop = 1;
                if (h.lo_a != 4'd15) begin wa[n_wr] = h.lo_a; wd[n_wr] = h.lo_d; n_wr++; end
            end
        end else if (has) begin
            pop = 1;
            if (h.lo_a != 4'd15) begin wa[n_wr] = h.lo_a; wd[n_wr] = h.lo_d; n_wr++; end
            if (h.is_long && h.hi_a != h.lo_a && h.hi_a != 4'd15) begin
                wa[n_wr] = h.hi_a; wd[n_wr] = h.hi_d; n_wr++;
            end
        end
        exp_we = (n_wr > 0);
        exp_a1 = wa[0]; exp_d1 = wd[0];
        exp_a2 = (n_wr == 2) ? wa[1] : wa[0];
        exp_d2 = (n_wr == 2) ? wd[1] : wd[0];
        if (pop) begin
            if (h.lo_a != 4'd15) m_busy[h.lo_a] = 1'b0;
            if (h.is_long && h.hi_a != 4'd15) m_busy[h.hi_a] = 1'b0;
        end
        if (iss_valid) begin
            if (iss_lo_a != 4'd15) m_busy[iss_lo_a] = 1'b1;
            if (iss_long && iss_hi_a != 4'd15) m_busy[iss_hi_a] = 1'b1;
        end
        if (pop) begin
            m_run = 0; m_starve = 0;
        end else if (!has) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run > STARVE_LIMIT) m_starve = 1;
        end
        if (pop) void'(m_q.pop_front());
        if (mul_valid && room)
            m_q.push_back('{is_long: mul_long, lo_a: mul_lo_a, hi_a: mul_hi_a,
                            lo_d: mul_lo_d, hi_d: mul_hi_d});
    endtask

    // One clock: model, edge, then compare every output against the model.
    task automatic cycle();
        if (wb_valid && wb_a != 4'd15)
            check_eq("contract_wb_not_busy", 32'(busy[wb_a]), 32'd0);
        model_step();
        @(posedge clk);
        #1;
        check_eq("we3", 32'(we3), 32'(exp_we));
        if (exp_we) begin
            check_eq("wa3", 32'(wa3), 32'(exp_a1));
            check_eq("wd3", wd3, exp_d1);
            check_eq("wa3_2", 32'(wa3_2), 32'(exp_a2));
            check_eq("wd3_2", wd3_2, exp_d2);
        end
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("wb_hold", 32'(wb_hold), 32'(m_starve));
        check_eq("mul_ready", 32'(mul_ready), 32'(m_q.size() < DEPTH));
    endtask

    task automatic idle();
        reset = 1'b0; wb_valid = 1'b0; wb_a = 4'd0; wb_d = 32'd0;
        iss_valid = 1'b0; iss_lo_a = 4'd0; iss_hi_a = 4'd0; iss_long = 1'b0;
        mul_valid = 1'b0; mul_long = 1'b0; mul_lo_a = 4'd0; mul_hi_a = 4'd0;
        mul_lo_d = 32'd0; mul_hi_d = 32'd0;
    endtask

    task automatic set_mul(input bit lng, input logic [3:0] lo, input logic [3:0] hi,
                           input logic [31:0] lod, input logic [31:0] hid);
        mul_valid = 1'b1; mul_long = lng; mul_lo_a = lo; mul_hi_a = hi;
        mul_lo_d = lod; mul_hi_d = hid;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_busy = '0; m_run = 0; m_starve = 0;
        idle();
        reset = 1'b1;
        cycle(); cycle();
        check_eq("rst_we3", 32'(we3), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(mul_ready), 32'd1);

        // Plain WB write, visible for exactly one cycle
        idle(); wb_valid = 1'b1; wb_a = 4'd3; wb_d = 32'hDEADBEEF;
        cycle();
        check_eq("t1_wa3_2", 32'(wa3_2), 32'd3);
        check_eq("t1_wd3_2", wd3_2, 32'hDEADBEEF);
        idle(); cycle();
        check_eq("t1_we3_off", 32'(we3), 32'd0);

        // Long multiply issue, result, drain
        idle(); iss_valid = 1'b1; iss_long = 1'b1; iss_lo_a = 4'd4; iss_hi_a = 4'd5;
        cycle();
        check_eq("t2_busy", 32'(busy), 32'h0030);
        idle(); set_mul(1'b1, 4'd4, 4'd5, 32'h1, 32'h2);
        cycle();
        idle(); cycle();
        check_eq("t2_wa3", 32'(wa3), 32'd4);
        check_eq("t2_wd3_2", wd3_2, 32'h2);
        check_eq("t2_wa3_2", 32'(wa3_2), 32'd5);
        check_eq("t2_busy_clr", 32'(busy), 32'd0);

        // Merge of WB with a queued non-long result
        idle(); set_mul(1'b0, 4'd6, 4'd0, 32'hAA, 32'h0);
        cycle();
        idle(); wb_valid = 1'b1; wb_a = 4'd2; wb_d = 32'h55;
        cycle();
        check_eq("t3_wd3", wd3, 32'h55);
        check_eq("t3_wa3_2", 32'(wa3_2), 32'd6);
        check_eq("t3_wd3_2", wd3_2, 32'hAA);
        idle(); cycle();

        // Starvation: WB held high while two long results queue up
        idle(); wb_valid = 1'b1; wb_a = 4'd1; wb_d = 32'h11;
        set_mul(1'b1, 4'd8, 4'd9, 32'h80, 32'h90);
        cycle();
        set_mul(1'b1, 4'd10, 4'd11, 32'hA0, 32'hB0);
        cycle();
        check_eq("t4_full", 32'(mul_ready), 32'd0);
        mul_valid = 1'b0;
        for (int i = 0; i < 12 && !m_starve; i++) cycle();
        check_eq("t4_hold_on", 32'(wb_hold), 32'd1);
        idle(); cycle();
        check_eq("t4_hold_off", 32'(wb_hold), 32'd0);
        check_eq("t4_pop1", 32'(wa3), 32'd8);
        cycle();
        check_eq("t4_pop2", 32'(wa3_2), 32'd11);

        // PC-targeted halves are suppressed
        idle(); iss_valid = 1'b1; iss_long = 1'b1; iss_lo_a = 4'd15; iss_hi_a = 4'd7;
        cycle();
        check_eq("t5_busy", 32'(busy), 32'h0080);
        idle(); set_mul(1'b1, 4'd15, 4'd7, 32'h15, 32'h77);
        cycle();
        idle(); cycle();
        check_eq("t5_wa3", 32'(wa3), 32'd7);
        check_eq("t5_wa3_2", 32'(wa3_2), 32'd7);
        check_eq("t5_wd3", wd3, 32'h77);

        // Reset with queued entries and busy registers
        idle(); iss_valid = 1'b1; iss_long = 1'b1; iss_lo_a = 4'd10; iss_hi_a = 4'd11;
        cycle();
        check_eq("t6_busy", 32'(busy), 32'h0C00);
        idle(); wb_valid = 1'b1; wb_a = 4'd1; wb_d = 32'h1;
        set_mul(1'b1, 4'd10, 4'd11, 32'h100, 32'h110); cycle();
        set_mul(1'b1, 4'd12, 4'd13, 32'h120, 32'h130); cycle();
        idle(); reset = 1'b1; cycle();
        check_eq("t6_busy_rst", 32'(busy), 32'd0);
        check_eq("t6_ready_rst", 32'(mul_ready), 32'd1);
        check_eq("t6_we3_rst", 32'(we3), 32'd0);
        idle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("t6_no_write", 32'(we3), 32'd0);
        end

        // Randomized traffic
        iss_q.delete();
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] cand;
            idle();
            reset = ($urandom_range(0, 249) == 0);
            if (!m_starve && $urandom_range(0, 99) < 55) begin
                for (int t = 0; t < 16 && !wb_valid; t++) begin
                    cand = 4'($urandom_range(0, 14));
                    if (!m_busy[cand]) begin
                        wb_valid = 1'b1; wb_a = cand; wb_d = $urandom();
                    end
                end
            end
            if (iss_q.size() < 6 && $urandom_range(0, 99) < 25) begin
                iss_valid = 1'b1;
                iss_long  = 1'($urandom_range(0, 1));
                iss_lo_a  = 4'($urandom_range(0, 15));
                iss_hi_a  = 4'($urandom_range(0, 15));
                iss_q.push_back('{is_long: iss_long, lo_a: iss_lo_a, hi_a: iss_hi_a,
                                  lo_d: 32'd0, hi_d: 32'd0});
            end
            if ($urandom_range(0, 99) < 40) begin
                if (iss_q.size() > 0 && $urandom_range(0, 99) < 70) begin
                    set_mul(iss_q[0].is_long, iss_q[0].lo_a, iss_q[0].hi_a, $urandom(), $urandom());
                    if (!reset && m_q.size() < DEPTH) void'(iss_q.pop_front());
                end else begin
                    set_mul(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                            4'($urandom_range(0, 15)), $urandom(), $urandom());
                end
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
